uart_rx: RTL

//  Serial receiver for the rider-authentication link. Samples the asynchronous RX pin,

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync2.sv | 21 ++
 rtl/uart_rx.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, default divider and auth-link command bytes
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, presets to 1 so an idle-high line
// never shows a spurious falling edge when reset is released
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sync <= 2'b11;
        else
            r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first; samples each bit at mid-bit and holds the last
// good byte with a sticky ready flag, pulsing frm_err when the stop bit is low
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    rx_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_rdy, w_rdy_nxt;
    logic          r_frm, w_frm_nxt;
    logic          r_rx_prev;
    logic          w_rx, w_fall, w_tick;

    sync2 u_sync (.clk(clk), .rst_n(rst_n), .i_d(RX), .o_q(w_rx));

    assign w_fall = r_rx_prev & ~w_rx;
    assign w_tick = r_baud == '0;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_tick ? r_baud : r_baud - 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_rdy_nxt   = r_rdy & ~clr_rdy;
        w_frm_nxt   = 1'b0;
        case (r_state)
            IDLE: if (w_fall) begin
                w_state_nxt = START;
                w_baud_nxt  = HALF;
                w_bit_nxt   = 3'd0;
                w_rdy_nxt   = 1'b0;
            end
            START: if (w_tick) begin
                w_state_nxt = w_rx ? IDLE : DATA;
                w_baud_nxt  = FULL;
            end
            DATA: if (w_tick) begin
                w_shift_nxt = {w_rx, r_shift[7:1]};
                w_bit_nxt   = r_bit + 3'd1;
                w_baud_nxt  = FULL;
                w_state_nxt = (r_bit == 3'd7) ? STOP : DATA;
            end
            STOP: if (w_tick) begin
                // leaving at mid stop bit lets a directly following start edge be caught
                w_state_nxt = IDLE;
                w_data_nxt  = w_rx ? r_shift : r_data;
                w_rdy_nxt   = w_rx | w_rdy_nxt;
                w_frm_nxt   = ~w_rx;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_rdy     <= 1'b0;
            r_frm     <= 1'b0;
            r_rx_prev <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_rdy     <= w_rdy_nxt;
            r_frm     <= w_frm_nxt;
            r_rx_prev <= w_rx;
        end
    end

    assign rx_data = r_data;
    assign rdy     = r_rdy;
    assign frm_err = r_frm;

endmodule
